// File: rtl/multicycle_control_if.sv
// Shared instruction/data memory port between the multi-cycle sequencer and memory.
// The controller drives the request side; memory answers with mem_ready.
interface multicycle_control_if;
   logic mem_req;
   logic mem_we;
   logic mem_ready;

   modport master (output mem_req, output mem_we, input mem_ready);
   modport slave  (input mem_req, input mem_we, output mem_ready);
endinterface

// File: rtl/multicycle_control.sv
// Multi-cycle RV32I-subset sequencer: steps each instruction through
// FETCH/DECODE/EXEC/MEM/WB over one memory port and drives datapath controls per state.
module multicycle_control #(
   parameter int MEM_TIMEOUT = 15
) (
   input  logic                        clk,
   input  logic                        rst_n,
   multicycle_control_if.master        bus,
   input  logic [31:0]                 instr,
   output logic                        ir_write,
   output logic                        pc_write,
   output logic                        alu_src,
   output logic                        mem_to_reg,
   output logic                        reg_write,
   output logic                        branch,
   output logic [1:0]                  alu_op,
   output logic                        jump,
   output logic                        jump_r,
   output logic                        retire,
   output logic                        illegal,
   output logic                        bus_err,
   output logic [2:0]                  state
);

   localparam int CW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
   localparam logic [CW-1:0] LAST_WAIT = CW'(MEM_TIMEOUT - 1);

   localparam logic [6:0] OPC_R    = 7'b0110011;
   localparam logic [6:0] OPC_I    = 7'b0010011;
   localparam logic [6:0] OPC_B    = 7'b1100011;
   localparam logic [6:0] OPC_JAL  = 7'b1101111;
   localparam logic [6:0] OPC_JALR = 7'b1100111;
   localparam logic [6:0] OPC_LW   = 7'b0000011;
   localparam logic [6:0] OPC_SW   = 7'b0100011;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      FETCH  = 3'd1,
      DECODE = 3'd2,
      EXEC   = 3'd3,
      MEM    = 3'd4,
      WB     = 3'd5,
      HALT   = 3'd6
   } state_t;

   state_t        state_q, state_n;
   logic [6:0]    opcode_q;
   logic [CW-1:0] wait_cnt;
   logic          legal;
   logic          timeout;
   logic          unused_instr;

   assign unused_instr = ^instr[31:7];
   assign state        = state_q;
   assign timeout      = (wait_cnt == LAST_WAIT);

   // The illegal pulse must appear in DECODE itself, before opcode_q is loaded,
   // so legality is the one decision taken from the live IR opcode.
   assign legal = instr[6:0] inside {OPC_R, OPC_I, OPC_B, OPC_JAL, OPC_JALR, OPC_LW, OPC_SW};

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         opcode_q <= '0;
         wait_cnt <= '0;
      end else begin
         state_q <= state_n;
         if (state_q == DECODE)
            opcode_q <= instr[6:0];
         if (state_n != state_q)
            wait_cnt <= '0;
         else if ((state_q == FETCH || state_q == MEM) && !bus.mem_ready)
            wait_cnt <= wait_cnt + 1'b1;
      end
   end

   // NOTE: every output and state_n gets a default first, so no path through
   // the case statement can infer a latch.
   always_comb begin
      state_n     = state_q;
      bus.mem_req = 1'b0;
      bus.mem_we  = 1'b0;
      ir_write    = 1'b0;
      pc_write    = 1'b0;
      alu_src     = 1'b0;
      mem_to_reg  = 1'b0;
      reg_write   = 1'b0;
      branch      = 1'b0;
      alu_op      = 2'b00;
      jump        = 1'b0;
      jump_r      = 1'b0;
      retire      = 1'b0;
      illegal     = 1'b0;
      bus_err     = 1'b0;

      case (state_q)
         IDLE: state_n = FETCH;
         FETCH: begin
            bus.mem_req = 1'b1;
            if (bus.mem_ready) begin
               ir_write = 1'b1;
               state_n  = DECODE;
            end else if (timeout) begin
               bus_err = 1'b1;
               state_n = HALT;
            end
         end
         DECODE: begin
            if (legal) begin
               state_n = EXEC;
            end else begin
               illegal  = 1'b1;
               pc_write = 1'b1;
               state_n  = FETCH;
            end
         end
         EXEC: begin
            case (opcode_q)
               OPC_R: begin
                  alu_op  = 2'b10;
                  state_n = WB;
               end
               OPC_I: begin
                  alu_src = 1'b1;
                  alu_op  = 2'b11;
                  state_n = WB;
               end
               OPC_B: begin
                  alu_op   = 2'b01;
                  branch   = 1'b1;
                  pc_write = 1'b1;
                  retire   = 1'b1;
                  state_n  = FETCH;
               end
               OPC_JAL: begin
                  jump    = 1'b1;
                  state_n = WB;
               end
               OPC_JALR: begin
                  alu_src = 1'b1;
                  jump_r  = 1'b1;
                  state_n = WB;
               end
               OPC_LW, OPC_SW: begin
                  alu_src = 1'b1;
                  state_n = MEM;
               end
               default: state_n = FETCH;
            endcase
         end
         MEM: begin
            bus.mem_req = 1'b1;
            bus.mem_we  = (opcode_q == OPC_SW);
            alu_src     = 1'b1;
            if (bus.mem_ready) begin
               if (opcode_q == OPC_SW) begin
                  pc_write = 1'b1;
                  retire   = 1'b1;
                  state_n  = FETCH;
               end else begin
                  state_n = WB;
               end
            end else if (timeout) begin
               bus_err = 1'b1;
               state_n = HALT;
            end
         end
         WB: begin
            reg_write  = 1'b1;
            pc_write   = 1'b1;
            retire     = 1'b1;
            mem_to_reg = (opcode_q == OPC_LW);
            jump       = (opcode_q == OPC_JAL);
            jump_r     = (opcode_q == OPC_JALR);
            alu_src    = (opcode_q == OPC_I);
            state_n    = FETCH;
         end
         HALT: state_n = HALT;
         default: state_n = IDLE;
      endcase
   end

endmodule
